fetch_top: RTL and testbench
============================

Name: fetch_top

Overview:
Instruction fetch stage; producer of the fetch_instr_valid/data/pc and fetch exception interface that the decode stage consumes.
- Holds the PC and looks it up in a small direct-mapped instruction cache.
- On a miss, refills the line from memory through a request/response handshake.
- Applies branch and exception redirects.
- Holds its outputs stable while decode is stalled.

Parameters:
BOOT_PC, 32'h0000_1000, PC value loaded at reset.
XCPT_PC, 32'h0000_2000, redirect target on an exception redirect.
IC_LINES, 4, number of cache lines (power of 2, at least 2).
LINE_BYTES, 16, bytes per line (power of 2, at least 4); LINE_BITS = 8*LINE_BYTES.
PC_WIDTH, 32, PC and address width.
INSTR_WIDTH, 32, instruction width.

Ports:
clock  in  1  single clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-low reset.
stall_fetch  in  1  decode stalled: hold PC and outputs.
branch_valid  in  1  taken branch/jump from ALU.
branch_pc  in  PC_WIDTH  branch target.
xcpt_redirect_valid  in  1  exception taken in WB; redirect to XCPT_PC.
mem_req_valid  out  1  line refill request.
mem_req_ready  in  1  memory accepts the request.
mem_req_addr  out  PC_WIDTH  line-aligned refill address.
mem_rsp_valid  in  1  refill data valid (one-cycle pulse).
mem_rsp_data  in  LINE_BITS  refill line; word 0 in bits [31:0].
fetch_instr_valid  out  1  instruction valid to decode.
fetch_instr_data  out  INSTR_WIDTH  instruction.
fetch_instr_pc  out  PC_WIDTH  instruction PC.
xcpt_fetch_out  out  fetch_xcpt_t  fetch exception to decode/WB.

Behaviour:
Reset (asynchronous, active-low):
- pc_ff = BOOT_PC.
- All line valid bits = 0.
- State = IDLE.
- fetch_instr_valid = 0; fetch_instr_data = 0; fetch_instr_pc = 0.
- xcpt_fetch_out = 0.
- mem_req_valid = 0; mem_req_addr = 0.

Address split:
- offset = log2(LINE_BYTES) bits.
- index = next log2(IC_LINES) bits.
- tag = remaining upper bits.
- word select = pc_ff[offset-1:2].

FSM states: IDLE, MISS_REQ, MISS_WAIT.

IDLE:
- Lookup pc_ff combinationally.
- Hit and !stall_fetch: register valid=1, data=selected word, pc=pc_ff; pc_ff += 4. Latency is 1 cycle, giving 1 instruction per cycle on consecutive hits.
- Miss and !stall_fetch: output valid=0; go to MISS_REQ.
- Misaligned PC (pc_ff[1:0] != 0): no lookup and no memory request. Register valid=1, xcpt_fetch_out.xcpt_misaligned=1, xcpt_pc=pc_ff. pc_ff is held until a redirect arrives.

MISS_REQ:
- mem_req_valid=1; mem_req_addr = pc_ff with the offset bits cleared.
- Stay until mem_req_ready=1, then go to MISS_WAIT. Valid drops the cycle after the handshake.

MISS_WAIT:
- On mem_rsp_valid: write data/tag/valid into the line at the request's index; go to IDLE.
- The original PC is then replayed and hits.

Stall:
- While stall_fetch=1, all outputs, pc_ff and the cache lookup result are frozen.
- A miss FSM already in MISS_REQ/MISS_WAIT keeps running; the fill completes.

Redirects:
- xcpt_redirect_valid has priority over branch_valid when both are asserted.
- Redirect applies even while stalled.
- Effect: pc_ff = target; next-cycle fetch_instr_valid = 0 (squash); xcpt_fetch_out is cleared.
- Redirect during MISS_REQ: the request is abandoned only if the handshake has not yet occurred (mem_req_valid drops); go to IDLE.
- Redirect during MISS_WAIT: keep waiting, complete the fill, return to IDLE, then fetch from the new PC. The refill is never forwarded to decode.

Wrap-around:
- pc_ff increments modulo 2^PC_WIDTH.

Other rules:
- Only one outstanding memory request at any time.
- A stray mem_rsp_valid in IDLE is ignored.

Decomposition:
Shared package (soc.vh):
- fetch_xcpt_t {xcpt_misaligned; xcpt_pc[PC_WIDTH]}.
- Constants: BOOT_PC, XCPT_PC, IC_LINES, LINE_BYTES.
- Range macros for the tag, index and offset fields.

Sub-module icache_array:
- Contents: tag, valid and data storage.
- Ports: read by index; write on fill; async valid clear on reset.
- Responsibility: the FSM and PC logic stay in fetch_top.

Test Plan:
- Cold start: release reset, memory ready=1, response 3 cycles later with line words 0x11,0x22,0x33,0x44 -> mem_req_addr=0x1000 once; then valid on 4 consecutive cycles, PCs 0x1000/4/8/C with matching data; next request 0x1010.
- Stall on hit: with the line at 0x1000 resident, hold stall_fetch=1 for 3 cycles at PC 0x1004 -> outputs unchanged (pc=0x1004, data=0x22); 0x1008 appears the cycle after release.
- Branch: branch_valid with branch_pc=0x1008 while streaming -> next cycle valid=0; following cycle pc=0x1008, data=0x33.
- Simultaneous redirects: xcpt_redirect_valid and branch_valid (0x1004) in the same cycle -> fetch resumes from 0x2000 (miss request to 0x2000).
- Redirect during MISS_WAIT to 0x1000: fill of the 0x2000 line completes silently, with no valid output of its data; next output is pc 0x1000.
- Misaligned branch_pc=0x1002 -> valid=1, xcpt_misaligned=1, xcpt_pc=0x1002, no memory request.
- Asynchronous reset asserted mid-MISS_REQ -> mem_req_valid=0 immediately and all lines invalid.
- After reset release, the first request is 0x1000.

Source files
------------

// File: rtl/fetch_top_pkg.sv
// Shared fetch-stage types and default constants.
package fetch_top_pkg;

  localparam int unsigned PC_WIDTH    = 32;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam logic [31:0] BOOT_PC     = 32'h0000_1000;
  localparam logic [31:0] XCPT_PC     = 32'h0000_2000;
  localparam int unsigned IC_LINES    = 4;
  localparam int unsigned LINE_BYTES  = 16;
  localparam int unsigned LINE_BITS   = 8 * LINE_BYTES;

  // Address field ranges: [TAG_MSB:TAG_LSB] tag, [IDX_MSB:OFF_BITS] index, [OFF_BITS-1:0] offset
  localparam int unsigned OFF_BITS = $clog2(LINE_BYTES);
  localparam int unsigned IDX_BITS = $clog2(IC_LINES);
  localparam int unsigned IDX_MSB  = OFF_BITS + IDX_BITS - 1;
  localparam int unsigned TAG_LSB  = OFF_BITS + IDX_BITS;
  localparam int unsigned TAG_MSB  = PC_WIDTH - 1;

  typedef struct packed {
    logic                xcpt_misaligned;
    logic [PC_WIDTH-1:0] xcpt_pc;
  } fetch_xcpt_t;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    MISS_WAIT
  } fetch_state_t;

endpackage

// File: rtl/fetch_top_icache_array.sv
// Direct-mapped instruction cache storage: tag, valid and line data.
module icache_array #(
  parameter int unsigned IC_LINES   = 4,
  parameter int unsigned INDEX_BITS = 2,
  parameter int unsigned TAG_BITS   = 26,
  parameter int unsigned LINE_BITS  = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [LINE_BITS-1:0]  rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [LINE_BITS-1:0]  wr_data
);

  logic [IC_LINES-1:0]  valid_q;
  logic [TAG_BITS-1:0]  tag_q  [IC_LINES];
  logic [LINE_BITS-1:0] data_q [IC_LINES];

  // Valid bits: cleared asynchronously on reset, set by a line fill
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage: written on fill, no reset needed behind valid
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/fetch_top.sv
// Instruction fetch stage: PC, direct-mapped I-cache lookup, miss refill, redirects.
module fetch_top #(
  parameter logic [31:0] BOOT_PC     = fetch_top_pkg::BOOT_PC,
  parameter logic [31:0] XCPT_PC     = fetch_top_pkg::XCPT_PC,
  parameter int unsigned IC_LINES    = fetch_top_pkg::IC_LINES,
  parameter int unsigned LINE_BYTES  = fetch_top_pkg::LINE_BYTES,
  parameter int unsigned PC_WIDTH    = fetch_top_pkg::PC_WIDTH,
  parameter int unsigned INSTR_WIDTH = fetch_top_pkg::INSTR_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stall_fetch,
  input  logic                      branch_valid,
  input  logic [PC_WIDTH-1:0]       branch_pc,
  input  logic                      xcpt_redirect_valid,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [PC_WIDTH-1:0]       mem_req_addr,
  input  logic                      mem_rsp_valid,
  input  logic [8*LINE_BYTES-1:0]   mem_rsp_data,
  output logic                      fetch_instr_valid,
  output logic [INSTR_WIDTH-1:0]    fetch_instr_data,
  output logic [PC_WIDTH-1:0]       fetch_instr_pc,
  output fetch_top_pkg::fetch_xcpt_t xcpt_fetch_out
);

  import fetch_top_pkg::*;

  localparam int unsigned LB_BITS   = 8 * LINE_BYTES;
  localparam int unsigned O_BITS    = $clog2(LINE_BYTES);
  localparam int unsigned I_BITS    = $clog2(IC_LINES);
  localparam int unsigned T_LSB     = O_BITS + I_BITS;
  localparam int unsigned T_BITS    = PC_WIDTH - T_LSB;
  localparam int unsigned WORD_BITS = O_BITS - 2;

  fetch_state_t               state;
  logic [PC_WIDTH-1:0]        pc_ff;

  logic [I_BITS-1:0]          lu_index;
  logic [T_BITS-1:0]          lu_tag;
  logic                       rd_valid;
  logic [T_BITS-1:0]          rd_tag;
  logic [LB_BITS-1:0]         rd_data;
  logic [INSTR_WIDTH-1:0]     rd_word;
  logic                       hit;
  logic                       misaligned;
  logic                       redirect;
  logic [PC_WIDTH-1:0]        redirect_pc;
  logic [PC_WIDTH-1:0]        line_base;
  logic                       fill_en;

  assign lu_index    = pc_ff[T_LSB-1:O_BITS];
  assign lu_tag      = pc_ff[PC_WIDTH-1:T_LSB];
  assign hit         = rd_valid && (rd_tag == lu_tag);
  assign misaligned  = (pc_ff[1:0] != 2'b00);
  assign redirect    = xcpt_redirect_valid || branch_valid;
  assign redirect_pc = xcpt_redirect_valid ? PC_WIDTH'(XCPT_PC) : branch_pc;
  assign line_base   = {pc_ff[PC_WIDTH-1:O_BITS], {O_BITS{1'b0}}};
  assign fill_en     = (state == MISS_WAIT) && mem_rsp_valid;

  generate
    if (WORD_BITS == 0) begin : g_one_word
      assign rd_word = rd_data[INSTR_WIDTH-1:0];
    end else begin : g_word_sel
      assign rd_word = rd_data[pc_ff[O_BITS-1:2]*INSTR_WIDTH +: INSTR_WIDTH];
    end
  endgenerate

  // The fill targets the line recorded in mem_req_addr, since pc_ff may
  // have been redirected while the refill was outstanding.
  icache_array #(
    .IC_LINES  (IC_LINES),
    .INDEX_BITS(I_BITS),
    .TAG_BITS  (T_BITS),
    .LINE_BITS (LB_BITS)
  ) u_icache_array (
    .clock   (clock),
    .reset   (reset),
    .rd_index(lu_index),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (fill_en),
    .wr_index(mem_req_addr[T_LSB-1:O_BITS]),
    .wr_tag  (mem_req_addr[PC_WIDTH-1:T_LSB]),
    .wr_data (mem_rsp_data)
  );

  // Fetch FSM: PC update, registered decode outputs and refill handshake
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      pc_ff             <= PC_WIDTH'(BOOT_PC);
      fetch_instr_valid <= 1'b0;
      fetch_instr_data  <= '0;
      fetch_instr_pc    <= '0;
      xcpt_fetch_out    <= '0;
      mem_req_valid     <= 1'b0;
      mem_req_addr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            pc_ff             <= redirect_pc;
            fetch_instr_valid <= 1'b0;
            xcpt_fetch_out    <= '0;
          end else if (!stall_fetch) begin
            if (misaligned) begin
              fetch_instr_valid              <= 1'b1;
              fetch_instr_pc                 <= pc_ff;
              xcpt_fetch_out.xcpt_misaligned <= 1'b1;
              xcpt_fetch_out.xcpt_pc         <= pc_ff;
            end else if (hit) begin
              fetch_instr_valid <= 1'b1;
              fetch_instr_data  <= rd_word;
              fetch_instr_pc    <= pc_ff;
              xcpt_fetch_out    <= '0;
              pc_ff             <= pc_ff + PC_WIDTH'(4);
            end else begin
              fetch_instr_valid <= 1'b0;
              mem_req_valid     <= 1'b1;
              mem_req_addr      <= line_base;
              state             <= MISS_REQ;
            end
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= MISS_WAIT;
          end
          // A redirect abandons the request only if it was not accepted this cycle
          if (redirect) begin
            pc_ff             <= redirect_pc;
            fetch_instr_valid <= 1'b0;
            xcpt_fetch_out    <= '0;
            if (!mem_req_ready) begin
              mem_req_valid <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        MISS_WAIT: begin
          if (redirect) begin
            pc_ff             <= redirect_pc;
            fetch_instr_valid <= 1'b0;
            xcpt_fetch_out    <= '0;
          end
          if (mem_rsp_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_top.sv
// Directed self-checking bench for fetch_top.
module tb_fetch_top;
  import fetch_top_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  stall_fetch;
  logic                  branch_valid;
  logic [31:0]           branch_pc;
  logic                  xcpt_redirect_valid;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [31:0]           mem_req_addr;
  logic                  mem_rsp_valid;
  logic [127:0]          mem_rsp_data;
  logic                  fetch_instr_valid;
  logic [31:0]           fetch_instr_data;
  logic [31:0]           fetch_instr_pc;
  fetch_xcpt_t           xcpt_fetch_out;

  int unsigned tests = 0;
  int unsigned fails = 0;

  localparam logic [127:0] LINE_A = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] LINE_B = {32'hB4, 32'hB3, 32'hB2, 32'hB1};
  localparam logic [127:0] LINE_C = {32'hC3, 32'hC2, 32'hC1, 32'hC0};

  fetch_top u_dut (
    .clock              (clock),
    .reset              (reset),
    .stall_fetch        (stall_fetch),
    .branch_valid       (branch_valid),
    .branch_pc          (branch_pc),
    .xcpt_redirect_valid(xcpt_redirect_valid),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_addr       (mem_req_addr),
    .mem_rsp_valid      (mem_rsp_valid),
    .mem_rsp_data       (mem_rsp_data),
    .fetch_instr_valid  (fetch_instr_valid),
    .fetch_instr_data   (fetch_instr_data),
    .fetch_instr_pc     (fetch_instr_pc),
    .xcpt_fetch_out     (xcpt_fetch_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] data);
    check({tag, "_valid"}, 64'(fetch_instr_valid), 64'(v));
    check({tag, "_pc"},    64'(fetch_instr_pc),    64'(pc));
    check({tag, "_data"},  64'(fetch_instr_data),  64'(data));
  endtask

  task automatic branch_to(input logic [31:0] target);
    branch_valid = 1'b1;
    branch_pc    = target;
    tick();
    branch_valid = 1'b0;
  endtask

  task automatic respond(input logic [127:0] line);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = line;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
  endtask

  initial begin
    reset = 1'b0;
    stall_fetch = 1'b0;
    branch_valid = 1'b0;
    branch_pc = '0;
    xcpt_redirect_valid = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;

    // Reset state
    repeat (2) tick();
    check("rst_valid", 64'(fetch_instr_valid), 64'd0);
    check("rst_data", 64'(fetch_instr_data), 64'd0);
    check("rst_pc", 64'(fetch_instr_pc), 64'd0);
    check("rst_xcpt", 64'(xcpt_fetch_out), 64'd0);
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_req_addr", 64'(mem_req_addr), 64'd0);
    @(negedge clock) reset = 1'b1;

    // Cold start
    tick();
    check("cold_req_valid", 64'(mem_req_valid), 64'd1);
    check("cold_req_addr", 64'(mem_req_addr), 64'h1000);
    check("cold_out_valid", 64'(fetch_instr_valid), 64'd0);
    tick();
    check("cold_req_drop", 64'(mem_req_valid), 64'd0);
    tick();
    tick();
    check("cold_req_once", 64'(mem_req_valid), 64'd0);
    respond(LINE_A);
    check("cold_fill_silent", 64'(fetch_instr_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("cold_stream", 1'b1, 32'h1000 + 32'(4 * i), 32'h11 * 32'(i + 1));
    end
    tick();
    check("next_line_valid", 64'(fetch_instr_valid), 64'd0);
    check("next_line_req", 64'(mem_req_valid), 64'd1);
    check("next_line_addr", 64'(mem_req_addr), 64'h1010);

    // Redirect before handshake abandons the request
    mem_req_ready = 1'b0;
    branch_to(32'h1004);
    check("abandon_req_valid", 64'(mem_req_valid), 64'd0);
    check("abandon_out_valid", 64'(fetch_instr_valid), 64'd0);
    tick();
    check_out("resume_1004", 1'b1, 32'h1004, 32'h22);

    // Stall on hit
    stall_fetch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall_hold", 1'b1, 32'h1004, 32'h22);
    end
    stall_fetch = 1'b0;
    tick();
    check_out("stall_release", 1'b1, 32'h1008, 32'h33);
    tick();
    check_out("stream_100c", 1'b1, 32'h100C, 32'h44);

    // Branch while streaming
    branch_to(32'h1008);
    check("branch_squash", 64'(fetch_instr_valid), 64'd0);
    tick();
    check_out("branch_target", 1'b1, 32'h1008, 32'h33);

    // Simultaneous exception and branch redirects
    xcpt_redirect_valid = 1'b1;
    branch_to(32'h1004);
    xcpt_redirect_valid = 1'b0;
    check("xcpt_squash", 64'(fetch_instr_valid), 64'd0);
    tick();
    check("xcpt_req_valid", 64'(mem_req_valid), 64'd1);
    check("xcpt_req_addr", 64'(mem_req_addr), 64'h2000);
    tick();
    check("req_held_not_ready", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    tick();
    check("xcpt_req_accepted", 64'(mem_req_valid), 64'd0);

    // Redirect during MISS_WAIT: the 0x2000 fill is not forwarded
    branch_to(32'h1000);
    check("wait_redirect_valid", 64'(fetch_instr_valid), 64'd0);
    respond(LINE_B);
    check("wait_fill_silent", 64'(fetch_instr_valid), 64'd0);
    tick();
    check("evicted_valid", 64'(fetch_instr_valid), 64'd0);
    check("evicted_req", 64'(mem_req_valid), 64'd1);
    check("evicted_req_addr", 64'(mem_req_addr), 64'h1000);
    tick();
    check("refill_wait_valid", 64'(fetch_instr_valid), 64'd0);
    respond(LINE_A);
    check("refill_silent", 64'(fetch_instr_valid), 64'd0);
    tick();
    check_out("after_redirect", 1'b1, 32'h1000, 32'h11);

    // Misaligned branch target
    branch_to(32'h1002);
    check("mis_squash", 64'(fetch_instr_valid), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("mis_valid", 64'(fetch_instr_valid), 64'd1);
      check("mis_flag", 64'(xcpt_fetch_out.xcpt_misaligned), 64'd1);
      check("mis_xpc", 64'(xcpt_fetch_out.xcpt_pc), 64'h1002);
      check("mis_no_req", 64'(mem_req_valid), 64'd0);
    end
    branch_to(32'h1000);
    check("mis_clear_valid", 64'(fetch_instr_valid), 64'd0);
    check("mis_clear_xcpt", 64'(xcpt_fetch_out), 64'd0);

    // Stray response in IDLE must not touch the cache
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = LINE_B;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    check_out("stray_hit0", 1'b1, 32'h1000, 32'h11);
    tick();
    check_out("stray_hit1", 1'b1, 32'h1004, 32'h22);

    // Asynchronous reset in MISS_REQ
    mem_req_ready = 1'b0;
    branch_to(32'h1010);
    tick();
    check("pre_rst_req", 64'(mem_req_valid), 64'd1);
    check("pre_rst_addr", 64'(mem_req_addr), 64'h1010);
    #2 reset = 1'b0;
    #1;
    check("async_rst_req", 64'(mem_req_valid), 64'd0);
    check("async_rst_valid", 64'(fetch_instr_valid), 64'd0);
    check("async_rst_addr", 64'(mem_req_addr), 64'd0);
    tick();
    @(negedge clock) reset = 1'b1;
    tick();
    check("post_rst_req", 64'(mem_req_valid), 64'd1);
    check("post_rst_addr", 64'(mem_req_addr), 64'h1000);
    mem_req_ready = 1'b1;
    tick();
    respond(LINE_A);
    tick();
    check_out("post_rst_hit", 1'b1, 32'h1000, 32'h11);

    // PC wrap-around
    branch_to(32'hFFFF_FFFC);
    tick();
    check("wrap_req_addr", 64'(mem_req_addr), 64'hFFFF_FFF0);
    tick();
    respond(LINE_C);
    tick();
    check_out("wrap_last", 1'b1, 32'hFFFF_FFFC, 32'hC3);
    tick();
    check("wrap_miss_valid", 64'(fetch_instr_valid), 64'd0);
    check("wrap_req", 64'(mem_req_valid), 64'd1);
    check("wrap_req_zero", 64'(mem_req_addr), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
